// File: rtl/mc_main_control.sv
// Multicycle MIPS main-control FSM: decodes opcode, sequences fetch/decode/execute/memory/writeback.
// Optional addi support is enabled by defining MC_CTRL_ADDI_EN.
module mc_main_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EX    = 4'd6,
    S_R_WB    = 4'd7,
    S_BR      = 4'd8,
    S_JMP     = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             illegal_q, timeout_q;
  logic             illegal_hit, timeout_hit;
  logic             in_wait, at_limit;

  assign in_wait  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign at_limit = (wait_q == CNT_W'(MEM_TIMEOUT - 1));

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = S_FETCH;
    wait_d      = '0;
    illegal_hit = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EX;
          OP_BEQ:       state_d = S_BR;
          OP_J:         state_d = S_JMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default: begin
            state_d     = S_FETCH;
            illegal_hit = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EX:     state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BR:       state_d = S_FETCH;
      S_JMP:      state_d = S_FETCH;
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ADDI_WB:  state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase

    // A stalled memory state either times out or keeps counting; mem_ready always wins.
    if (in_wait && !mem_ready) begin
      if (at_limit) begin
        timeout_hit = 1'b1;
        state_d     = S_FETCH;
      end else begin
        wait_d = wait_q + CNT_W'(1);
      end
    end
  end

  // alu_op is registered from the next state so the ALU-control register sees it one edge early.
  always_comb begin
    case (state_d)
      S_R_EX:  alu_op_d = 2'b10;
      S_BR:    alu_op_d = 2'b01;
      default: alu_op_d = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      alu_op_q  <= 2'b00;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      alu_op_q <= alu_op_d;
      if (illegal_hit) illegal_q <= 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EX:     alu_src_a = 1'b1;
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BR: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB:  reg_write = 1'b1;
`endif
      default: ;
    endcase

    // An instruction abandoned by reset must not commit anything in the reset cycle.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
    end
  end

  assign alu_op      = alu_op_q;
  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: directed literal sequences, then random opcodes/mem_ready/reset
// checked every cycle against a route-list model of the instruction flow.
`timescale 1ns/1ps
module tb_mc_main_control;

  localparam int T = 4;
  localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5;
  localparam int R_EX = 6, R_WB = 7, BR = 8, JMP = 9, ADDI_EX = 10, ADDI_WB = 11;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [3:0] state;
  logic       illegal_op, mem_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: current state, wait cycles so far, sticky flags, and remaining states of the instruction.
  int   m_state = FETCH;
  int   m_wait  = 0;
  bit   m_ill   = 1'b0;
  bit   m_to    = 1'b0;
  int   plan[$];
  logic [5:0] cur_op = OP_R;

  mc_main_control #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected strobe/select vector for a state, straight from the per-state output table.
  function automatic logic [15:0] exp_vec(input int s, input bit rdy);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, ps, ao;
    pw = 1'b0; pwc = 1'b0; iod = 1'b0; mr = 1'b0; mw = 1'b0;
    irw = 1'b0; m2r = 1'b0; rd = 1'b0; rw = 1'b0; sa = 1'b0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (s)
      FETCH:    begin mr = 1'b1; sb = 2'b01; pw = rdy; irw = rdy; end
      DECODE:   sb = 2'b11;
      MEM_ADDR: begin sa = 1'b1; sb = 2'b10; end
      MEM_RD:   begin mr = 1'b1; iod = 1'b1; end
      MEM_WB:   begin rw = 1'b1; m2r = 1'b1; end
      MEM_WR:   begin mw = 1'b1; iod = 1'b1; end
      R_EX:     begin sa = 1'b1; ao = 2'b10; end
      R_WB:     begin rw = 1'b1; rd = 1'b1; end
      BR:       begin sa = 1'b1; ao = 2'b01; pwc = 1'b1; ps = 2'b01; end
      JMP:      begin pw = 1'b1; ps = 2'b10; end
      ADDI_EX:  begin sa = 1'b1; sb = 2'b10; end
      ADDI_WB:  rw = 1'b1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ps, ao};
  endfunction

  task automatic load_plan(input logic [5:0] op, output bit legal);
    plan.delete();
    legal = 1'b1;
    case (op)
      OP_LW:  plan = '{MEM_ADDR, MEM_RD, MEM_WB};
      OP_SW:  plan = '{MEM_ADDR, MEM_WR};
      OP_R:   plan = '{R_EX, R_WB};
      OP_BEQ: plan = '{BR};
      OP_J:   plan = '{JMP};
`ifdef MC_CTRL_ADDI_EN
      OP_ADDI: plan = '{ADDI_EX, ADDI_WB};
`endif
      default: legal = 1'b0;
    endcase
  endtask

  task automatic model_step(input bit r, input logic [5:0] op, input bit rdy);
    bit legal;
    if (r) begin
      m_state = FETCH; m_wait = 0; m_ill = 1'b0; m_to = 1'b0;
      plan.delete();
    end else if (m_state == FETCH || m_state == MEM_RD || m_state == MEM_WR) begin
      if (rdy) begin
        m_wait = 0;
        if (m_state == FETCH) m_state = DECODE;
        else m_state = (plan.size() != 0) ? plan.pop_front() : FETCH;
      end else if (m_wait == T - 1) begin
        m_to = 1'b1; m_wait = 0; m_state = FETCH;
        plan.delete();
      end else begin
        m_wait++;
      end
    end else if (m_state == DECODE) begin
      load_plan(op, legal);
      if (!legal) m_ill = 1'b1;
      m_state = (plan.size() != 0) ? plan.pop_front() : FETCH;
    end else begin
      m_state = (plan.size() != 0) ? plan.pop_front() : FETCH;
    end
  endtask

  // One clock: drive at negedge, compare shortly after, then advance the model across the posedge.
  task automatic step(input bit r, input logic [5:0] op, input bit rdy);
    @(negedge clk);
    rst = r; opcode = op; mem_ready = rdy;
    #1;
    if (r) begin
      check("reset_strobes", {pc_write, pc_write_cond, mem_write, ir_write, reg_write}, 5'b0);
    end else begin
      check("state", state, m_state);
      check("outputs", {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                        mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op},
            exp_vec(m_state, rdy));
      check("flags", {illegal_op, mem_timeout}, {m_ill, m_to});
    end
    model_step(r, op, rdy);
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(7))
      0: return OP_R;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_J;
      5: return OP_ADDI;
      default: return 6'($urandom_range(63));
    endcase
  endfunction

  initial begin
    bit r, rdy;
    rst = 1'b1; opcode = 6'b0; mem_ready = 1'b0;

    // Reset with mem_ready high: no PC load during reset, clean state afterwards.
    step(1'b1, OP_R, 1'b1);
    check("rst_pc_write", pc_write, 1'b0);

    // R-type: 0,1,6,7
    step(1'b0, OP_R, 1'b1);
    check("r_s0", state, 0); check("r_ir_write", ir_write, 1'b1);
    check("r_alu_op0", alu_op, 2'b00); check("r_flags0", {illegal_op, mem_timeout}, 2'b00);
    step(1'b0, OP_R, 1'b0); check("r_s1", state, 1);
    step(1'b0, OP_R, 1'b0); check("r_s6", state, 6); check("r_alu_op", alu_op, 2'b10);
    check("r_ex_no_wr", reg_write, 1'b0);
    step(1'b0, OP_R, 1'b0); check("r_s7", state, 7); check("r_wb", {reg_write, reg_dst}, 2'b11);

    // lw with three stalled MEM_RD cycles; ready arrives exactly at the timeout limit and wins.
    step(1'b0, OP_LW, 1'b1); check("lw_s0", state, 0);
    step(1'b0, OP_LW, 1'b0); check("lw_s1", state, 1);
    step(1'b0, OP_LW, 1'b0); check("lw_s2", state, 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, OP_LW, 1'b0); check("lw_s3_wait", state, 3);
    end
    step(1'b0, OP_LW, 1'b1); check("lw_s3_rdy", state, 3);
    step(1'b0, OP_LW, 1'b0); check("lw_s4", state, 4);
    check("lw_wb", {reg_write, mem_to_reg}, 2'b11); check("lw_no_to", mem_timeout, 1'b0);

    // beq then j
    step(1'b0, OP_BEQ, 1'b1); check("beq_s0", state, 0);
    step(1'b0, OP_BEQ, 1'b0); check("beq_s1", state, 1);
    step(1'b0, OP_BEQ, 1'b0); check("beq_s8", state, 8);
    check("beq_alu_op", alu_op, 2'b01); check("beq_pwc", pc_write_cond, 1'b1);
    step(1'b0, OP_J, 1'b1); check("j_s0", state, 0); check("j_pwc_off", pc_write_cond, 1'b0);
    step(1'b0, OP_J, 1'b0); check("j_s1", state, 1);
    step(1'b0, OP_J, 1'b0); check("j_s9", state, 9);
    check("j_pc", {pc_write, pc_source}, 3'b110);

    // Fetch timeout: four stalled FETCH cycles, then the sticky flag.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, OP_R, 1'b0);
      check("to_fetch", state, 0); check("to_no_ir", ir_write, 1'b0);
      check("to_flag_low", mem_timeout, 1'b0);
    end
    step(1'b0, OP_R, 1'b0); check("to_state", state, 0); check("to_flag", mem_timeout, 1'b1);

    // addi
    step(1'b0, OP_ADDI, 1'b1); check("addi_s0", state, 0);
    step(1'b0, OP_ADDI, 1'b0); check("addi_s1", state, 1);
    step(1'b0, OP_ADDI, 1'b0);
`ifdef MC_CTRL_ADDI_EN
    check("addi_s10", state, 10); check("addi_alu_op", alu_op, 2'b00);
    step(1'b0, OP_ADDI, 1'b0); check("addi_s11", state, 11); check("addi_wb", reg_write, 1'b1);
`else
    check("addi_illegal_s0", state, 0); check("addi_illegal", illegal_op, 1'b1);
`endif

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(99) < 2);
      rdy = ($urandom_range(9) < 6);
      if (m_state == FETCH) cur_op = pick_op();
      step(r, cur_op, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
